// File: rtl/sivers_gpio_pkg.sv
// Shared types and constants for the SIVERS_gpio AXI4-Lite arbiter slice.
package sivers_gpio_pkg;

   // Transaction sequencer states for the single shared AXI4-Lite master port
   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_WR_ADDR_DATA = 3'd1,
      ST_WR_RESP      = 3'd2,
      ST_RD_ADDR      = 3'd3,
      ST_RD_DATA      = 3'd4,
      ST_DONE         = 3'd5
   } state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   localparam logic [1:0] REG_IDX_0 = 2'd0;
   localparam logic [1:0] REG_IDX_1 = 2'd1;
   localparam logic [1:0] REG_IDX_2 = 2'd2;
   localparam logic [1:0] REG_IDX_3 = 2'd3;

   localparam int C_NUM_REGS = 4;

   // Registers are 32-bit words, so the byte address is the index shifted by two
   function automatic logic [3:0] reg_byte_addr(input logic [1:0] idx);
      logic [3:0] addr;
      unique case (idx)
         REG_IDX_0: addr = 4'h0;
         REG_IDX_1: addr = 4'h4;
         REG_IDX_2: addr = 4'h8;
         REG_IDX_3: addr = 4'hC;
         default:   addr = 4'h0;
      endcase
      return addr;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past the winner whenever a grant is taken.
module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W-1:0] cand;
   logic             found;

   // Modular increment that stays inside 0..NUM_REQ-1 for non power-of-two sizes
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NUM_REQ) begin
         sum = sum - NUM_REQ;
      end
      return PTR_W'(sum);
   endfunction

   // Scan requesters starting at the pointer and pick the first one asserted
   always_comb begin
      grant   = '0;
      win_idx = '0;
      cand    = '0;
      found   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = wrap_add(ptr, k);
         if (!found && req[cand]) begin
            found       = 1'b1;
            win_idx     = cand;
            grant[cand] = 1'b1;
         end
      end
   end

   // Advance the pointer past the winner only when the grant is actually used
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (enable && found) begin
         ptr <= wrap_add(win_idx, 1);
      end
   end

endmodule

// File: rtl/sivers_gpio_axil_arbiter.sv
// Shares one AXI4-Lite master port among NUM_REQ register requesters, running
// one single-word transaction at a time with round-robin arbitration.
module sivers_gpio_axil_arbiter
   import sivers_gpio_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int C_ADDR_WIDTH = 4,
   parameter int C_DATA_WIDTH = 32
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ-1:0]              req_wr,
   input  logic [2*NUM_REQ-1:0]            req_idx,
   input  logic [C_DATA_WIDTH*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]              rsp_done,
   output logic                            rsp_err,
   output logic [C_DATA_WIDTH-1:0]         rsp_rdata,
   output logic                            busy,
   output logic [C_ADDR_WIDTH-1:0]         m_axi_awaddr,
   output logic [2:0]                      m_axi_awprot,
   output logic                            m_axi_awvalid,
   input  logic                            m_axi_awready,
   output logic [C_DATA_WIDTH-1:0]         m_axi_wdata,
   output logic [C_DATA_WIDTH/8-1:0]       m_axi_wstrb,
   output logic                            m_axi_wvalid,
   input  logic                            m_axi_wready,
   input  logic [1:0]                      m_axi_bresp,
   input  logic                            m_axi_bvalid,
   output logic                            m_axi_bready,
   output logic [C_ADDR_WIDTH-1:0]         m_axi_araddr,
   output logic [2:0]                      m_axi_arprot,
   output logic                            m_axi_arvalid,
   input  logic                            m_axi_arready,
   input  logic [C_DATA_WIDTH-1:0]         m_axi_rdata,
   input  logic [1:0]                      m_axi_rresp,
   input  logic                            m_axi_rvalid,
   output logic                            m_axi_rready
);

   state_t state, state_nxt;

   logic [NUM_REQ-1:0]      grant;
   logic [NUM_REQ-1:0]      owner, owner_nxt;
   logic                    sel_wr;
   logic [1:0]              sel_idx;
   logic [C_DATA_WIDTH-1:0] sel_wdata;
   logic [C_ADDR_WIDTH-1:0] sel_addr;

   logic [NUM_REQ-1:0]      req_ready_nxt;
   logic [NUM_REQ-1:0]      rsp_done_nxt;
   logic                    rsp_err_nxt;
   logic [C_DATA_WIDTH-1:0] rsp_rdata_nxt;
   logic                    busy_nxt;
   logic [C_ADDR_WIDTH-1:0] awaddr_nxt;
   logic                    awvalid_nxt;
   logic [C_DATA_WIDTH-1:0] wdata_nxt;
   logic                    wvalid_nxt;
   logic                    bready_nxt;
   logic [C_ADDR_WIDTH-1:0] araddr_nxt;
   logic                    arvalid_nxt;
   logic                    rready_nxt;

   // Protection is always unprivileged/secure/data and every write is a full word
   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign m_axi_wstrb  = '1;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .clk    (ACLK),
      .rst_n  (ARESETN),
      .req    (req_valid),
      .enable (state == ST_IDLE),
      .grant  (grant)
   );

   // Pull the granted requester's command fields out of the packed buses
   always_comb begin
      sel_wr    = 1'b0;
      sel_idx   = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_wr    = req_wr[i];
            sel_idx   = req_idx[2*i +: 2];
            sel_wdata = req_wdata[C_DATA_WIDTH*i +: C_DATA_WIDTH];
         end
      end
      sel_addr = C_ADDR_WIDTH'(reg_byte_addr(sel_idx));
   end

   // Next-state and next-output decode; every output is registered below
   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      req_ready_nxt = '0;
      rsp_done_nxt  = '0;
      rsp_err_nxt   = rsp_err;
      rsp_rdata_nxt = rsp_rdata;
      busy_nxt      = busy;
      awaddr_nxt    = m_axi_awaddr;
      awvalid_nxt   = m_axi_awvalid;
      wdata_nxt     = m_axi_wdata;
      wvalid_nxt    = m_axi_wvalid;
      bready_nxt    = m_axi_bready;
      araddr_nxt    = m_axi_araddr;
      arvalid_nxt   = m_axi_arvalid;
      rready_nxt    = m_axi_rready;

      unique case (state)
         ST_IDLE: begin
            busy_nxt = 1'b0;
            if (|req_valid) begin
               req_ready_nxt = grant;
               owner_nxt     = grant;
               busy_nxt      = 1'b1;
               if (sel_wr) begin
                  awaddr_nxt  = sel_addr;
                  wdata_nxt   = sel_wdata;
                  awvalid_nxt = 1'b1;
                  wvalid_nxt  = 1'b1;
                  state_nxt   = ST_WR_ADDR_DATA;
               end else begin
                  araddr_nxt  = sel_addr;
                  arvalid_nxt = 1'b1;
                  state_nxt   = ST_RD_ADDR;
               end
            end
         end

         ST_WR_ADDR_DATA: begin
            if (m_axi_awvalid && m_axi_awready) begin
               awvalid_nxt = 1'b0;
            end
            if (m_axi_wvalid && m_axi_wready) begin
               wvalid_nxt = 1'b0;
            end
            if (!awvalid_nxt && !wvalid_nxt) begin
               bready_nxt = 1'b1;
               state_nxt  = ST_WR_RESP;
            end
         end

         ST_WR_RESP: begin
            if (m_axi_bvalid) begin
               bready_nxt    = 1'b0;
               rsp_done_nxt  = owner;
               rsp_err_nxt   = (m_axi_bresp != AXI_RESP_OKAY);
               rsp_rdata_nxt = '0;
               state_nxt     = ST_DONE;
            end
         end

         ST_RD_ADDR: begin
            if (m_axi_arready) begin
               arvalid_nxt = 1'b0;
               rready_nxt  = 1'b1;
               state_nxt   = ST_RD_DATA;
            end
         end

         ST_RD_DATA: begin
            if (m_axi_rvalid) begin
               rready_nxt    = 1'b0;
               rsp_done_nxt  = owner;
               rsp_err_nxt   = (m_axi_rresp != AXI_RESP_OKAY);
               rsp_rdata_nxt = m_axi_rdata;
               state_nxt     = ST_DONE;
            end
         end

         ST_DONE: begin
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight command silently
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state         <= ST_IDLE;
         owner         <= '0;
         req_ready     <= '0;
         rsp_done      <= '0;
         rsp_err       <= 1'b0;
         rsp_rdata     <= '0;
         busy          <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
      end else begin
         state         <= state_nxt;
         owner         <= owner_nxt;
         req_ready     <= req_ready_nxt;
         rsp_done      <= rsp_done_nxt;
         rsp_err       <= rsp_err_nxt;
         rsp_rdata     <= rsp_rdata_nxt;
         busy          <= busy_nxt;
         m_axi_awaddr  <= awaddr_nxt;
         m_axi_awvalid <= awvalid_nxt;
         m_axi_wdata   <= wdata_nxt;
         m_axi_wvalid  <= wvalid_nxt;
         m_axi_bready  <= bready_nxt;
         m_axi_araddr  <= araddr_nxt;
         m_axi_arvalid <= arvalid_nxt;
         m_axi_rready  <= rready_nxt;
      end
   end

endmodule

// File: tb/tb_sivers_gpio_axil_arbiter.sv
// Self-checking bench: memory-backed AXI4-Lite slave with ready delays, queued
// requesters, and a transaction-level reference model of arbitration and data.
module tb_sivers_gpio_axil_arbiter;
   import sivers_gpio_pkg::*;

   localparam int NUM_REQ = 2;

   typedef struct packed {
      logic        wr;
      logic [1:0]  idx;
      logic [31:0] data;
   } cmd_t;

   logic                    ACLK = 1'b0;
   logic                    ARESETN = 1'b0;
   logic [NUM_REQ-1:0]      req_valid = '0;
   logic [NUM_REQ-1:0]      req_ready;
   logic [NUM_REQ-1:0]      req_wr = '0;
   logic [2*NUM_REQ-1:0]    req_idx = '0;
   logic [32*NUM_REQ-1:0]   req_wdata = '0;
   logic [NUM_REQ-1:0]      rsp_done;
   logic                    rsp_err;
   logic [31:0]             rsp_rdata;
   logic                    busy;
   logic [3:0]              m_axi_awaddr;
   logic [2:0]              m_axi_awprot;
   logic                    m_axi_awvalid;
   logic                    m_axi_awready = 1'b0;
   logic [31:0]             m_axi_wdata;
   logic [3:0]              m_axi_wstrb;
   logic                    m_axi_wvalid;
   logic                    m_axi_wready = 1'b0;
   logic [1:0]              m_axi_bresp = 2'b00;
   logic                    m_axi_bvalid = 1'b0;
   logic                    m_axi_bready;
   logic [3:0]              m_axi_araddr;
   logic [2:0]              m_axi_arprot;
   logic                    m_axi_arvalid;
   logic                    m_axi_arready = 1'b0;
   logic [31:0]             m_axi_rdata = '0;
   logic [1:0]              m_axi_rresp = 2'b00;
   logic                    m_axi_rvalid = 1'b0;
   logic                    m_axi_rready;

   int vectors = 0;
   int miscompares = 0;

   // slave configuration and observation
   int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0;
   bit          err_en = 1'b0;
   logic [1:0]  err_idx = 2'd0;
   logic [31:0] slave_mem [4];
   int          b_count = 0;
   logic [3:0]  last_awaddr = '0;
   logic [31:0] last_wdata = '0;
   logic [3:0]  last_wstrb = '0;
   logic [2:0]  last_awprot = 3'b111;

   // reference model state
   cmd_t        cmd_q [NUM_REQ][$];
   logic [31:0] model_mem [4];
   int          model_ptr = 0;
   bit          out_valid = 1'b0;
   int          out_owner = 0;
   cmd_t        out_cmd;
   bit          out_exp_err = 1'b0;
   logic [NUM_REQ-1:0] prev_valid = '0;
   int          grant_cnt [NUM_REQ];
   int          grant_log [$];
   int          skew_aw_only = 0;
   int          skew_w_only = 0;

   sivers_gpio_axil_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .C_ADDR_WIDTH (4),
      .C_DATA_WIDTH (32)
   ) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_wr        (req_wr),
      .req_idx       (req_idx),
      .req_wdata     (req_wdata),
      .rsp_done      (rsp_done),
      .rsp_err       (rsp_err),
      .rsp_rdata     (rsp_rdata),
      .busy          (busy),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awprot  (m_axi_awprot),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready)
   );

   always #5 ACLK = ~ACLK;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input int req, input bit wr, input logic [1:0] idx, input logic [31:0] data);
      cmd_t c;
      c.wr   = wr;
      c.idx  = idx;
      c.data = data;
      cmd_q[req].push_back(c);
   endtask

   function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   // AXI4-Lite slave: samples handshakes at the edge, updates its outputs 1 time unit later
   initial begin
      bit aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got;
      logic [3:0]  s_awaddr, s_araddr, s_wstrb;
      logic [31:0] s_wdata, w_lat;
      logic [3:0]  aw_lat, strb_lat;
      logic [2:0]  prot_lat;
      int aw_cnt, w_cnt, ar_cnt, b_cnt;
      aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0;
      aw_lat = '0; w_lat = '0; strb_lat = '0; prot_lat = '0;
      for (int i = 0; i < 4; i++) slave_mem[i] = '0;
      forever begin
         @(posedge ACLK);
         aw_hs = m_axi_awvalid && m_axi_awready;
         w_hs  = m_axi_wvalid && m_axi_wready;
         b_hs  = m_axi_bvalid && m_axi_bready;
         ar_hs = m_axi_arvalid && m_axi_arready;
         r_hs  = m_axi_rvalid && m_axi_rready;
         s_awaddr = m_axi_awaddr; s_araddr = m_axi_araddr;
         s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb;
         if (aw_hs) prot_lat = m_axi_awprot;
         #1;
         if (!ARESETN) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0;
            aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0;
         end else begin
            if (b_hs) begin m_axi_bvalid = 0; b_count++; end
            if (r_hs) m_axi_rvalid = 0;
            if (aw_hs) begin
               m_axi_awready = 0; aw_got = 1; aw_lat = s_awaddr; aw_cnt = 0;
            end else if (m_axi_awvalid && !aw_got && !m_axi_awready) begin
               if (aw_cnt >= aw_delay) m_axi_awready = 1; else aw_cnt++;
            end
            if (w_hs) begin
               m_axi_wready = 0; w_got = 1; w_lat = s_wdata; strb_lat = s_wstrb; w_cnt = 0;
            end else if (m_axi_wvalid && !w_got && !m_axi_wready) begin
               if (w_cnt >= w_delay) m_axi_wready = 1; else w_cnt++;
            end
            if (aw_got && w_got && !m_axi_bvalid) begin
               if (b_cnt >= b_delay) begin
                  for (int b = 0; b < 4; b++)
                     if (strb_lat[b]) slave_mem[aw_lat[3:2]][8*b +: 8] = w_lat[8*b +: 8];
                  last_awaddr = aw_lat; last_wdata = w_lat; last_wstrb = strb_lat;
                  last_awprot = prot_lat;
                  m_axi_bvalid = 1; m_axi_bresp = AXI_RESP_OKAY;
                  aw_got = 0; w_got = 0; b_cnt = 0;
               end else begin
                  b_cnt++;
               end
            end
            if (ar_hs) begin
               m_axi_arready = 0; ar_cnt = 0;
               m_axi_rvalid = 1;
               m_axi_rdata  = slave_mem[s_araddr[3:2]];
               m_axi_rresp  = (err_en && s_araddr[3:2] == err_idx) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end else if (m_axi_arvalid && !m_axi_arready && !m_axi_rvalid) begin
               if (ar_cnt >= ar_delay) m_axi_arready = 1; else ar_cnt++;
            end
         end
      end
   end

   // One cycle of requester driving plus reference-model checking, run at negedge
   task automatic agent_step();
      int g;
      logic [31:0] exp_rdata;
      if (m_axi_awvalid && !m_axi_wvalid) skew_aw_only++;
      if (m_axi_wvalid && !m_axi_awvalid) skew_w_only++;
      if (req_ready != '0) begin
         g = rr_pick(prev_valid, model_ptr);
         if (g < 0 || out_valid) begin
            checkOutput("grant_unexpected", 32'(req_ready), 32'h0);
         end else begin
            checkOutput("grant", 32'(req_ready), 32'(1) << g);
            out_cmd     = cmd_q[g].pop_front();
            out_owner   = g;
            out_valid   = 1'b1;
            out_exp_err = !out_cmd.wr && err_en && (out_cmd.idx == err_idx);
            model_ptr   = (g + 1) % NUM_REQ;
            grant_cnt[g]++;
            grant_log.push_back(g);
         end
      end
      if (rsp_done != '0) begin
         if (!out_valid) begin
            checkOutput("done_unexpected", 32'(rsp_done), 32'h0);
         end else begin
            exp_rdata = out_cmd.wr ? 32'h0 : model_mem[out_cmd.idx];
            checkOutput("done_owner", 32'(rsp_done), 32'(1) << out_owner);
            checkOutput("rsp_err", 32'(rsp_err), 32'(out_exp_err));
            checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
            if (out_cmd.wr) model_mem[out_cmd.idx] = out_cmd.data;
            out_valid = 1'b0;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (cmd_q[i].size() != 0) begin
            req_valid[i]          = 1'b1;
            req_wr[i]             = cmd_q[i][0].wr;
            req_idx[2*i +: 2]     = cmd_q[i][0].idx;
            req_wdata[32*i +: 32] = cmd_q[i][0].data;
         end else begin
            req_valid[i] = 1'b0;
         end
      end
      prev_valid = req_valid;
   endtask

   task automatic tick();
      @(negedge ACLK);
      agent_step();
   endtask

   task automatic run_until_idle(input string tag);
      int c;
      c = 0;
      while ((cmd_q[0].size() != 0 || cmd_q[1].size() != 0 || out_valid) && c < 3000) begin
         tick();
         c++;
      end
      if (c >= 3000) checkOutput({tag, "_timeout"}, 32'h1, 32'h0);
      tick();
   endtask

   initial begin
      int start, b0, g0, g1;
      for (int i = 0; i < 4; i++) model_mem[i] = '0;
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] = 0;

      // reset state
      #2;
      checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
      checkOutput("rst_rsp_done", 32'(rsp_done), 32'h0);
      checkOutput("rst_rsp_err", 32'(rsp_err), 32'h0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_valids", {29'h0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 32'h0);
      checkOutput("rst_readies", {30'h0, m_axi_bready, m_axi_rready}, 32'h0);
      repeat (3) tick();
      ARESETN = 1'b1;
      tick();

      // single write
      applyStimulus(0, 1'b1, REG_IDX_2, 32'hDEADBEEF);
      run_until_idle("t1");
      checkOutput("t1_awaddr", 32'(last_awaddr), 32'h8);
      checkOutput("t1_wdata", last_wdata, 32'hDEADBEEF);
      checkOutput("t1_wstrb", 32'(last_wstrb), 32'hF);
      checkOutput("t1_awprot", 32'(last_awprot), 32'h0);

      // write then read from requester 1
      applyStimulus(1, 1'b1, REG_IDX_1, 32'h00000002);
      applyStimulus(1, 1'b0, REG_IDX_1, 32'h0);
      run_until_idle("t2");
      checkOutput("t2_readback_mem", model_mem[1], 32'h00000002);

      // contention: both requesters keep four commands queued
      start = grant_log.size();
      g0 = grant_cnt[0]; g1 = grant_cnt[1];
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
         applyStimulus(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
      end
      run_until_idle("t3");
      for (int k = 0; k < 8; k++) checkOutput("t3_order", 32'(grant_log[start + k]), 32'(k % 2));
      checkOutput("t3_grants0", 32'(grant_cnt[0] - g0), 32'd4);
      checkOutput("t3_grants1", 32'(grant_cnt[1] - g1), 32'd4);

      // ready skew: address accepted three cycles after data
      aw_delay = 3; w_delay = 0;
      skew_aw_only = 0; skew_w_only = 0; b0 = b_count;
      applyStimulus(0, 1'b1, REG_IDX_0, 32'h12345678);
      run_until_idle("t4");
      checkOutput("t4_aw_hold_cycles", 32'(skew_aw_only), 32'd3);
      checkOutput("t4_w_hold_cycles", 32'(skew_w_only), 32'd0);
      checkOutput("t4_b_count", 32'(b_count - b0), 32'd1);
      aw_delay = 0;

      // read error then a normal command
      err_en = 1'b1; err_idx = REG_IDX_3;
      applyStimulus(0, 1'b0, REG_IDX_3, 32'h0);
      applyStimulus(0, 1'b1, REG_IDX_3, 32'hA5A5_0003);
      run_until_idle("t5");
      err_en = 1'b0;

      // randomized rounds with random delays and error injection
      for (int r = 0; r < 6; r++) begin
         aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
         ar_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 2);
         err_en = 1'($urandom_range(0, 1)); err_idx = 2'($urandom_range(0, 3));
         for (int k = 0; k < 5; k++)
            applyStimulus(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), $urandom);
         run_until_idle("rand");
      end
      aw_delay = 0; w_delay = 0; ar_delay = 0; err_en = 1'b0;

      // reset while waiting for the write response
      b_delay = 8;
      applyStimulus(0, 1'b1, REG_IDX_2, 32'hCAFE0006);
      for (int c = 0; c < 100 && !out_valid; c++) tick();
      checkOutput("t6_granted", 32'(out_valid), 32'h1);
      applyStimulus(1, 1'b0, REG_IDX_2, 32'h0);
      for (int c = 0; c < 100 && !m_axi_bready; c++) tick();
      checkOutput("t6_in_wr_resp", 32'(m_axi_bready), 32'h1);
      ARESETN = 1'b0;
      #1;
      checkOutput("t6_valids", {29'h0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 32'h0);
      checkOutput("t6_readies", {30'h0, m_axi_bready, m_axi_rready}, 32'h0);
      checkOutput("t6_busy", 32'(busy), 32'h0);
      checkOutput("t6_done", 32'(rsp_done), 32'h0);
      out_valid = 1'b0;
      model_ptr = 0;
      b_delay = 0;
      repeat (3) tick();
      ARESETN = 1'b1;
      start = grant_log.size();
      run_until_idle("t6");
      checkOutput("t6_first_grant", 32'(grant_log.size() > start ? grant_log[start] : -1), 32'd1);
      checkOutput("t6_write_lost", model_mem[2], slave_mem[2]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
